// File: rtl/frame_tx_pkg.sv
// Shared definitions for the frame transmitter.
//   state_e     : frame FSM states (IDLE -> HDR -> PAYLOAD -> DONE)
//   HDR_BEATS   : number of header beats (one per matrix row)
//   MAT_ENTRIES : coefficient matrix size (3 rows x 4 lanes)
package frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } state_e;

    localparam int unsigned HDR_BEATS   = 3;
    localparam int unsigned MAT_ENTRIES = 12;

endpackage

// File: rtl/frame_tx_if.sv
// Bundle of the frame transmitter's config, command, upstream and AXIS signals.
//   master : the environment side (drives config/command/upstream data, m_tready)
//   slave  : the frame_tx side (drives p_tready, AXIS output and status)
interface frame_tx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                        cfg_we;
    logic [3:0]                  cfg_addr;
    logic [DATA_WIDTH-1:0]       cfg_wdata;
    logic                        start;
    logic [CNT_WIDTH-1:0]        num_points;
    logic [LANES*DATA_WIDTH-1:0] p_tdata;
    logic                        p_tvalid;
    logic                        p_tready;
    logic [LANES*DATA_WIDTH-1:0] m_tdata;
    logic                        m_tvalid;
    logic                        m_tready;
    logic                        m_tlast;
    logic                        busy;
    logic                        done;
    logic                        err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, num_points, p_tdata, p_tvalid, m_tready,
        input  p_tready, m_tdata, m_tvalid, m_tlast, busy, done, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, num_points, p_tdata, p_tvalid, m_tready,
        output p_tready, m_tdata, m_tvalid, m_tlast, busy, done, err
    );
endinterface

// File: rtl/frame_tx_axis_out_reg.sv
// Single-stage AXIS output register (module axis_out_reg).
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_data_i/in_valid_i   : beat offered by the source ({last,data})
//   in_ready_o             : register can take a beat this cycle
//   out_data_o/out_valid_o : registered beat towards the consumer
//   out_ready_i            : consumer ready
// Accepts a new beat while the current one leaves, so full rate needs no bubble.
module axis_out_reg #(
    parameter int unsigned W = 65
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (in_valid_i && in_ready_o) begin
            data_d  = in_data_i;
            valid_d = 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
endmodule

// File: rtl/frame_tx.sv
// AXIS frame transmitter: holds a 12-entry coefficient matrix and, per start,
// emits 3 header beats (matrix rows) followed by num_points forwarded points.
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus (slave)   : cfg_we/cfg_addr/cfg_wdata matrix writes, start/num_points
//                   command, p_* upstream point stream, m_* AXIS output,
//                   busy/done/err status
module frame_tx
    import frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic     aclk,
    input  logic     aresetn,
    frame_tx_if.slave bus
);
    localparam int unsigned BEAT_W = LANES * DATA_WIDTH;

    state_e                          state_q, state_d;
    logic [1:0]                      hdr_idx_q, hdr_idx_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d, num_q, num_d;
    logic [MAT_ENTRIES*DATA_WIDTH-1:0] mat_q, mat_d;
    logic                            err_q, err_d;

    logic              idle, start_ok, cfg_ok, p_ready;
    logic              ld_valid, ld_ready, ld_last, out_valid;
    logic [BEAT_W-1:0] ld_data, hdr_row;
    logic [1:0]        beat_sel;
    logic [BEAT_W:0]   out_word;

    assign idle     = (state_q == ST_IDLE);
    assign start_ok = idle && bus.start && (bus.num_points != '0);
    // A start in the same cycle takes priority and drops the write.
    assign cfg_ok   = idle && bus.cfg_we && !bus.start && (bus.cfg_addr < 4'(MAT_ENTRIES));
    assign err_d    = (bus.start && !start_ok) || (bus.cfg_we && !cfg_ok);

    // Matrix is row-major with element 0 in the LSBs, so row k is one contiguous slice.
    assign hdr_row = (beat_sel < 2'(HDR_BEATS)) ? mat_q[32'(beat_sel) * BEAT_W +: BEAT_W] : '0;

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        mat_d     = mat_q;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        p_ready   = 1'b0;
        beat_sel  = hdr_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    // Output register is always empty in IDLE, so beat 0 loads now.
                    state_d   = ST_HDR;
                    num_d     = bus.num_points;
                    cnt_d     = '0;
                    beat_sel  = 2'd0;
                    ld_valid  = 1'b1;
                    ld_data   = hdr_row;
                    hdr_idx_d = 2'd1;
                end else if (cfg_ok) begin
                    mat_d[32'(bus.cfg_addr) * DATA_WIDTH +: DATA_WIDTH] = bus.cfg_wdata;
                end
            end
            ST_HDR: begin
                if (hdr_idx_q != 2'(HDR_BEATS)) begin
                    ld_valid = 1'b1;
                    ld_data  = hdr_row;
                    if (ld_ready) hdr_idx_d = hdr_idx_q + 2'd1;
                end else if (out_valid && bus.m_tready) begin
                    // Last header beat handshakes: payload may start next cycle.
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                p_ready  = (cnt_q != num_q) && ld_ready;
                ld_valid = bus.p_tvalid && (cnt_q != num_q);
                ld_data  = bus.p_tdata;
                ld_last  = ((cnt_q + CNT_WIDTH'(1)) == num_q);
                if (bus.p_tvalid && p_ready) cnt_d = cnt_q + CNT_WIDTH'(1);
                if (out_valid && bus.m_tready && out_word[BEAT_W]) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            hdr_idx_q <= '0;
            cnt_q     <= '0;
            num_q     <= '0;
            mat_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            mat_q     <= mat_d;
            err_q     <= err_d;
        end
    end

    axis_out_reg #(
        .W(BEAT_W + 1)
    ) u_out (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .in_data_i  ({ld_last, ld_data}),
        .in_valid_i (ld_valid),
        .in_ready_o (ld_ready),
        .out_data_o (out_word),
        .out_valid_o(out_valid),
        .out_ready_i(bus.m_tready)
    );

    assign bus.p_tready = p_ready;
    assign bus.m_tdata  = out_word[BEAT_W-1:0];
    assign bus.m_tlast  = out_word[BEAT_W];
    assign bus.m_tvalid = out_valid;
    assign bus.busy     = !idle;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_frame_tx.sv
module tb_frame_tx;
    localparam int DW = 16;
    localparam int LN = 4;
    localparam int CW = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    frame_tx_if #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) bus ();

    frame_tx #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    // Model state
    beat_t       exp_q[$];
    logic [15:0] mat_m[12];
    bit          active, last_hs_prev, err_prev, stall_prev;
    int          hdr_left, pts_left, beats_seen;
    logic [63:0] seen[16];
    logic [63:0] prev_data;
    logic        prev_last;
    bit          p_hs_s, start_acc_s;
    int          cyc = 0;

    // Stimulus state
    logic [63:0] pts[16];
    int          pt_n = 0;
    int          pt_idx = 0;
    bit          rdy_mode = 0;
    bit          gap_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model + per-cycle compare, sampled away from the active edge.
    always @(negedge aclk) begin
        bit    hs, sacc, rej, exp_done;
        beat_t b;
        cyc++;
        if (!aresetn) begin
            for (int i = 0; i < 12; i++) mat_m[i] = '0;
            exp_q.delete();
            active = 0; last_hs_prev = 0; err_prev = 0; stall_prev = 0;
            hdr_left = 0; pts_left = 0; p_hs_s = 0; start_acc_s = 0;
        end else begin
            exp_done = last_hs_prev;
            chk("done", bus.done, exp_done);
            chk("busy", bus.busy, active);
            chk("err", bus.err, err_prev);
            if (exp_q.size() == 0) chk("idle_valid", bus.m_tvalid, 1'b0);
            if (stall_prev)
                chk("stall_hold", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, prev_last, prev_data});
            chk("p_tready", bus.p_tready,
                active && hdr_left == 0 && pts_left > 0 && (!bus.m_tvalid || bus.m_tready));
            hs = bus.m_tvalid && bus.m_tready;
            last_hs_prev = 0;
            if (hs && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", bus.m_tdata, b.data);
                chk("beat_last", bus.m_tlast, b.last);
                if (beats_seen < 16) seen[beats_seen] = bus.m_tdata;
                beats_seen++;
                if (hdr_left > 0) hdr_left--;
                last_hs_prev = b.last;
            end
            p_hs_s = bus.p_tvalid && bus.p_tready;
            if (p_hs_s) pts_left--;
            sacc = bus.start && !active && bus.num_points != 0;
            rej  = (bus.start && !sacc) || (bus.cfg_we && (active || bus.start || bus.cfg_addr >= 12));
            err_prev = rej;
            if (bus.cfg_we && !active && !bus.start && bus.cfg_addr < 12)
                mat_m[bus.cfg_addr] = bus.cfg_wdata;
            if (exp_done) active = 0;
            if (sacc) begin
                active = 1; hdr_left = 3; pts_left = int'(bus.num_points); beats_seen = 0;
                for (int r = 0; r < 3; r++)
                    exp_q.push_back({1'b0, mat_m[4*r+3], mat_m[4*r+2], mat_m[4*r+1], mat_m[4*r]});
                for (int i = 0; i < int'(bus.num_points); i++)
                    exp_q.push_back({(i == int'(bus.num_points) - 1), pts[i]});
            end
            start_acc_s = sacc;
            stall_prev  = bus.m_tvalid && !bus.m_tready;
            prev_data   = bus.m_tdata;
            prev_last   = bus.m_tlast;
        end
    end

    // Upstream point source and consumer ready pattern.
    always @(posedge aclk) begin
        #1;
        if (start_acc_s) pt_idx = 0;
        else if (p_hs_s) pt_idx++;
        bus.p_tvalid = (pt_idx < pt_n) && !(gap_en && (cyc % 3 == 1));
        bus.p_tdata  = (pt_idx < pt_n) ? pts[pt_idx] : '0;
        bus.m_tready = rdy_mode ? cyc[0] : 1'b1;
    end

    task automatic cmd_write(input logic [3:0] a, input logic [15:0] d);
        @(posedge aclk); #1;
        bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
        @(posedge aclk); #1;
        bus.cfg_we = 0;
    endtask

    task automatic cmd_start(input logic [15:0] n);
        @(posedge aclk); #1;
        bus.start = 1; bus.num_points = n;
        @(posedge aclk); #1;
        bus.start = 0;
    endtask

    task automatic cmd_write_start(input logic [3:0] a, input logic [15:0] d, input logic [15:0] n);
        @(posedge aclk); #1;
        bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
        bus.start = 1; bus.num_points = n;
        @(posedge aclk); #1;
        bus.cfg_we = 0; bus.start = 0;
    endtask

    task automatic wait_end(input string name);
        for (int i = 0; i < 300; i++) begin
            @(posedge aclk); #2;
            if (!active && exp_q.size() == 0) return;
        end
        total++; bad++;
        $display("FAIL %s_timeout: frame still open, %0d beats pending", name, exp_q.size());
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 300; i++) begin
            @(posedge aclk); #2;
            if (beats_seen >= n) return;
        end
        total++; bad++;
        $display("FAIL beats_timeout: seen %0d want %0d", beats_seen, n);
    endtask

    initial begin
        logic [63:0] s;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.start = 0; bus.num_points = '0;
        bus.p_tvalid = 0; bus.p_tdata = '0; bus.m_tready = 1;
        #1 aresetn = 0;
        #1;
        chk("reset_state", {bus.p_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.busy, bus.done, bus.err}, '0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1;

        // 1: basic frame, full rate
        for (int i = 0; i < 12; i++) cmd_write(4'(i), 16'h0100 + 16'(i));
        pts[0] = 64'h1111_2222_3333_4444;
        pts[1] = 64'h5555_6666_7777_8888;
        pt_n = 2;
        cmd_start(16'd2);
        chk("hdr0_latency", {bus.m_tvalid, bus.m_tdata}, {1'b1, 64'h0103_0102_0101_0100});
        wait_end("t1");
        chk("t1_beats", beats_seen, 5);
        chk("t1_hdr1", seen[1], 64'h0107_0106_0105_0104);
        chk("t1_hdr2", seen[2], 64'h010B_010A_0109_0108);
        chk("t1_p1", seen[4], 64'h5555_6666_7777_8888);

        // 2: same frame with backpressure and upstream gaps
        rdy_mode = 1; gap_en = 1;
        cmd_start(16'd2);
        wait_end("t2");
        chk("t2_p0", seen[3], 64'h1111_2222_3333_4444);
        rdy_mode = 0; gap_en = 0;

        // 3: zero-length start rejected
        cmd_start(16'd0);
        chk("t3_err", bus.err, 1'b1);
        chk("t3_busy", {bus.busy, bus.m_tvalid}, 2'b00);
        repeat (3) @(posedge aclk);

        // 4: config write and start during payload are rejected
        for (int i = 0; i < 6; i++) pts[i] = 64'hA000_0000_0000_0000 + 64'(i);
        pt_n = 6; rdy_mode = 1;
        cmd_start(16'd6);
        wait_beats(4);
        cmd_write(4'd0, 16'hDEAD);
        chk("t4_err_cfg", bus.err, 1'b1);
        cmd_start(16'd3);
        chk("t4_err_start", bus.err, 1'b1);
        wait_end("t4");
        rdy_mode = 0; pt_n = 1;
        cmd_start(16'd1);
        wait_end("t4b");
        s = seen[0];
        chk("t4_mat0_kept", s[15:0], 16'h0100);

        // 5: out-of-range address, and write colliding with start
        cmd_write(4'd12, 16'h7777);
        chk("t5_err_addr", bus.err, 1'b1);
        cmd_write_start(4'd0, 16'hBEEF, 16'd1);
        chk("t5_err_busy", {bus.err, bus.busy}, 2'b11);
        wait_end("t5");
        s = seen[0];
        chk("t5_mat0_kept", s[15:0], 16'h0100);
        s = seen[2];
        chk("t5_mat11_kept", s[63:48], 16'h010B);

        // 6: reset mid-payload
        for (int i = 0; i < 5; i++) pts[i] = 64'hC000_0000_0000_0000 + 64'(i);
        pt_n = 5;
        cmd_start(16'd5);
        wait_beats(5);
        #1 aresetn = 0;
        #1;
        chk("t6_reset_outputs", {bus.p_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.busy, bus.done, bus.err}, '0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1;
        pts[0] = 64'h9999_0000_9999_0000;
        pt_n = 1;
        cmd_start(16'd1);
        chk("t6_hdr_zero", {bus.m_tvalid, bus.m_tdata}, {1'b1, 64'h0});
        wait_end("t6");
        chk("t6_point", seen[3], 64'h9999_0000_9999_0000);

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
